// File: rtl/xor_parity_pkg.sv
// Shared definitions for the XOR parity receiver and its accumulator.
package xor_parity_pkg;

    // Receiver frame-deframing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // Default word size and the bit-counter width that goes with it
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W      = $clog2(DATA_W_DEF);

    // Error statistics counter width
    localparam int unsigned STATS_W = 16;

    // Bit-counter width for an arbitrary word size; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/xor_parity_acc.sv
// Single-bit running XOR; clear presets to ODD_PARITY so the final value is the
// parity-error indication directly. Shared with the transmit-side generator.
module xor_parity_acc #(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic acc
);

    // Accumulator register: clear has priority over enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= ODD_PARITY;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/xor_parity_rx.sv
// Serial frame receiver: start / DATA_W data bits (LSB first) / parity / stop.
// Received words are presented on a valid/ready port with a parity-error flag.
// Optional build macro XOR_PARITY_RX_STATS_EN adds saturating error counters.
module xor_parity_rx
    import xor_parity_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              bit_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
`ifdef XOR_PARITY_RX_STATS_EN
    ,
    output logic [STATS_W-1:0] par_err_cnt,
    output logic [STATS_W-1:0] frm_err_cnt
`endif
);

    localparam int unsigned BIT_CNT_W = cnt_width(DATA_W);

    rx_state_e             state;
    rx_state_e             state_nxt;
    logic [BIT_CNT_W-1:0]  cnt;
    logic [DATA_W-1:0]     shift_reg;
    logic                  par_acc;
    logic                  acc_clr;
    logic                  acc_en;
    logic                  last_bit;
    logic                  commit;
    logic                  frm_bad;
    logic                  load_ok;

    xor_parity_acc #(
        .ODD_PARITY (ODD_PARITY)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .din   (sin),
        .acc   (par_acc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-strobe control decode
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        commit    = 1'b0;
        frm_bad   = 1'b0;
        last_bit  = (cnt == BIT_CNT_W'(DATA_W - 1));
        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!sin) begin
                        state_nxt = DATA;
                        acc_clr   = 1'b1;
                    end
                end
                DATA: begin
                    acc_en = 1'b1;
                    if (last_bit) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    acc_en    = 1'b1;
                    state_nxt = STOP;
                end
                STOP: begin
                    commit    = sin;
                    frm_bad   = ~sin;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A committed word may load when the output slot is empty or being drained
    assign load_ok = ~dout_valid | dout_ready;

    // Data shift register and bit counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            shift_reg <= '0;
        end else if (bit_en) begin
            if (state == IDLE && !sin) begin
                cnt       <= '0;
                shift_reg <= '0;
            end else if (state == DATA) begin
                shift_reg[cnt] <= sin;
                if (!last_bit) begin
                    cnt <= cnt + BIT_CNT_W'(1);
                end
            end
        end
    end

    // Output word register, handshake, framing pulse and sticky overrun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= frm_bad;
            if (commit && load_ok) begin
                dout       <= shift_reg;
                parity_err <= par_acc;
                dout_valid <= 1'b1;
            end else begin
                if (commit) begin
                    overrun <= 1'b1;
                end
                if (dout_valid && dout_ready) begin
                    dout_valid <= 1'b0;
                end
            end
        end
    end

`ifdef XOR_PARITY_RX_STATS_EN
    // Saturating error statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err_cnt <= '0;
            frm_err_cnt <= '0;
        end else begin
            if (commit && load_ok && par_acc && (par_err_cnt != '1)) begin
                par_err_cnt <= par_err_cnt + STATS_W'(1);
            end
            if (frm_bad && (frm_err_cnt != '1)) begin
                frm_err_cnt <= frm_err_cnt + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_xor_parity_rx.sv
// Directed bench for xor_parity_rx: an even-parity and an odd-parity instance
// share strobe/ready; the selected instance sees the serial line, the other idles.
module tb_xor_parity_rx;
    import xor_parity_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line;
    logic       sel_odd;
    logic       bit_en;
    logic       dout_ready;
    logic       sin_e, sin_o;
    logic [7:0] dout_e, dout_o;
    logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, ov_e, ov_o;
`ifdef XOR_PARITY_RX_STATS_EN
    logic [15:0] pc_e, fc_e, pc_o, fc_o;
`endif

    logic [7:0] cur_dout;
    logic       cur_dv, cur_pe, cur_fe, cur_ov;

    int checks   = 0;
    int failures = 0;
    int gap      = 0;

    typedef struct {
        logic       odd;
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       ev;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
    } vec_t;

    vec_t tv [9];

    always #5 clk = ~clk;

    assign sin_e = sel_odd ? 1'b1 : line;
    assign sin_o = sel_odd ? line : 1'b1;

    assign cur_dout = sel_odd ? dout_o : dout_e;
    assign cur_dv   = sel_odd ? dv_o   : dv_e;
    assign cur_pe   = sel_odd ? pe_o   : pe_e;
    assign cur_fe   = sel_odd ? fe_o   : fe_e;
    assign cur_ov   = sel_odd ? ov_o   : ov_e;

    xor_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) u_e (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin_e),
        .bit_en     (bit_en),
        .dout       (dout_e),
        .dout_valid (dv_e),
        .dout_ready (dout_ready),
        .parity_err (pe_e),
        .frame_err  (fe_e),
        .overrun    (ov_e)
`ifdef XOR_PARITY_RX_STATS_EN
        ,
        .par_err_cnt (pc_e),
        .frm_err_cnt (fc_e)
`endif
    );

    xor_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) u_o (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin_o),
        .bit_en     (bit_en),
        .dout       (dout_o),
        .dout_valid (dv_o),
        .dout_ready (dout_ready),
        .parity_err (pe_o),
        .frame_err  (fe_o),
        .overrun    (ov_o)
`ifdef XOR_PARITY_RX_STATS_EN
        ,
        .par_err_cnt (pc_o),
        .frm_err_cnt (fc_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bit period: optional idle gap, then a single-cycle strobe; returns 1 after the edge
    task automatic strobe(input logic b);
        repeat (gap) @(posedge clk);
        @(negedge clk);
        line   = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        line   = 1'b1;
    endtask

    task automatic send_body(input logic [7:0] d, input logic p);
        strobe(1'b0);
        for (int i = 0; i < 8; i++) strobe(d[i]);
        strobe(p);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_body(d, p);
        strobe(s);
    endtask

    task automatic send_good(input string tag, input logic [7:0] d, input logic p);
        send_frame(d, p, 1'b1);
        check({tag, "_valid"}, 32'(cur_dv), 32'd1);
        check({tag, "_dout"},  32'(cur_dout), 32'(d));
        check({tag, "_perr"},  32'(cur_pe), 32'd0);
    endtask

    initial begin
        tv[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        tv[1] = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        tv[2] = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        tv[3] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[4] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        tv[5] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tv[6] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        tv[7] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        tv[8] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        // Reset with a toggling line and strobes, ending on a start bit
        rst_n      = 1'b0;
        line       = 1'b1;
        bit_en     = 1'b0;
        dout_ready = 1'b1;
        sel_odd    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            line   = ~line;
            bit_en = 1'b1;
        end
        @(posedge clk);
        #1;
        check("rst_dout",  32'(dout_e), 32'd0);
        check("rst_valid", 32'(dv_e), 32'd0);
        check("rst_perr",  32'(pe_e), 32'd0);
        check("rst_ferr",  32'(fe_e), 32'd0);
        check("rst_ovr",   32'(ov_e), 32'd0);
        check("rst_state", 32'(u_e.state), 32'(IDLE));
        @(negedge clk);
        rst_n  = 1'b1;
        bit_en = 1'b0;
        line   = 1'b1;
        // Remainder of the aborted frame (all ones) must not produce a word
        for (int i = 0; i < 10; i++) strobe(1'b1);
        check("rst_abort_valid", 32'(dv_e), 32'd0);
        check("rst_abort_state", 32'(u_e.state), 32'(IDLE));

        // Table-driven single frames, consumer always ready
        for (int i = 0; i < 9; i++) begin
            sel_odd = tv[i].odd;
            send_frame(tv[i].d, tv[i].p, tv[i].s);
            check($sformatf("tv%0d_valid", i), 32'(cur_dv), 32'(tv[i].ev));
            if (tv[i].ev) begin
                check($sformatf("tv%0d_dout", i), 32'(cur_dout), 32'(tv[i].ed));
                check($sformatf("tv%0d_perr", i), 32'(cur_pe), 32'(tv[i].epe));
            end
            check($sformatf("tv%0d_ferr", i), 32'(cur_fe), 32'(tv[i].efe));
            @(posedge clk);
            #1;
            check($sformatf("tv%0d_valid_drop", i), 32'(cur_dv), 32'd0);
            check($sformatf("tv%0d_ferr_drop", i), 32'(cur_fe), 32'd0);
        end
`ifdef XOR_PARITY_RX_STATS_EN
        check("stat_par_e", 32'(pc_e), 32'd1);
        check("stat_frm_e", 32'(fc_e), 32'd1);
        check("stat_par_o", 32'(pc_o), 32'd1);
`endif

        // Back-to-back frames with a strobe every 4th cycle
        gap     = 3;
        sel_odd = 1'b0;
        send_good("b2b_e0", 8'h00, 1'b0);
        send_good("b2b_e1", 8'hFF, 1'b0);
        send_good("b2b_e2", 8'h5A, 1'b0);
        sel_odd = 1'b1;
        send_good("b2b_o0", 8'h00, 1'b1);
        send_good("b2b_o1", 8'hFF, 1'b1);
        send_good("b2b_o2", 8'h5A, 1'b1);
        check("b2b_ovr_e", 32'(ov_e), 32'd0);
        check("b2b_ovr_o", 32'(ov_o), 32'd0);
        gap     = 0;
        sel_odd = 1'b0;

        // Held word replaced when ready coincides with the next commit
        dout_ready = 1'b0;
        send_good("hold_33", 8'h33, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_33_stable", 32'(dout_e), 32'h33);
        check("hold_33_valid",  32'(dv_e), 32'd1);
        send_body(8'h44, 1'b0);
        dout_ready = 1'b1;
        strobe(1'b1);
        check("swap_dout",  32'(dout_e), 32'h44);
        check("swap_valid", 32'(dv_e), 32'd1);
        check("swap_ovr",   32'(ov_e), 32'd0);
        @(posedge clk);
        #1;
        check("swap_drop", 32'(dv_e), 32'd0);

        // Overrun: second word dropped while the first is held
        dout_ready = 1'b0;
        send_good("ovr_11", 8'h11, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1);
        check("ovr_dout",  32'(dout_e), 32'h11);
        check("ovr_valid", 32'(dv_e), 32'd1);
        check("ovr_flag",  32'(ov_e), 32'd1);
        @(negedge clk);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_accept_valid", 32'(dv_e), 32'd0);
        check("ovr_sticky",       32'(ov_e), 32'd1);

        // Reset clears the sticky flag
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst2_ovr", 32'(ov_e), 32'd0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_parity_rx.md
Name: xor_parity_rx

Overview:
- Serial frame receiver that checks parity using a running XOR; it is the receive end of the team's XOR-based parity generator/serialiser.
- Accepts one bit per `bit_en` strobe and deframes start / data / parity / stop.
- Presents each received word on a valid/ready output, with a per-word parity-error flag and a sticky overrun flag.
- Sits between the line interface (already oversampled and retimed upstream) and the consumer logic.

Parameters:
- DATA_W, 8, number of data bits per frame (legal 1..32); data is sent LSB first.
- ODD_PARITY, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (XOR must be 1).

Ports:
- clk  input  1  single clock; all logic samples on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- sin  input  1  serial line; idles high.
- bit_en  input  1  one-cycle strobe marking one bit period; `sin` is sampled only when `bit_en`=1.
- dout  output  DATA_W  received data word.
- dout_valid  output  1  `dout` / `parity_err` hold a word.
- dout_ready  input  1  consumer accepts the word when `dout_valid`=1 and `dout_ready`=1.
- parity_err  output  1  parity mismatch for the word currently on `dout`.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  output  1  sticky; set when a completed frame is dropped. Cleared only by reset.

Behaviour:
- Reset (`rst_n`=0 at a clock edge):
  - FSM goes to IDLE.
  - `dout`=0, `dout_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0.
  - Shift register, bit counter and running parity are all cleared.
  - Reset mid-frame discards the partial frame. No output activity occurs until a new start bit.
- FSM states: IDLE, DATA, PARITY, STOP. State advances only on cycles with `bit_en`=1.
  - IDLE: `sin`=0 -> DATA. Counter=0 and `par_acc` = ODD_PARITY. `sin`=1 -> stay in IDLE.
  - DATA: shift `sin` into bit[counter] and set `par_acc ^= sin`. After the DATA_W-th bit -> PARITY.
  - PARITY: `par_acc ^= sin` -> STOP.
  - STOP, `sin`=1: the frame is good. Word is committed as `dout` = shifted data and `parity_err` = final `par_acc`.
  - STOP, `sin`=0: pulse `frame_err` for one cycle and discard the word. Parity is not reported.
  - STOP in either case -> IDLE.
- Parity rule:
  - `parity_err` = XOR(data bits, parity bit) XOR ODD_PARITY.
  - Even mode: for data 0x01 the correct parity bit is 1.
- Latency: `dout_valid` rises on the clock edge that samples the stop bit. It is visible the following cycle.
- Output handshake:
  - `dout`, `dout_valid` and `parity_err` stay stable while `dout_valid`=1 and `dout_ready`=0.
  - `dout_valid` drops the cycle after acceptance, unless a new word commits in that same cycle.
- Buffering: a one-word output register plus the frame shift register, so a full new frame can arrive while the previous word waits.
- Commit while output is occupied:
  - If `dout_valid`=1 and `dout_ready`=0 on the commit cycle, the new word is dropped, `overrun` is set, and the held word is kept.
  - If `dout_ready`=1 on the commit cycle, the old word is accepted and the new word loads in the same edge. `dout_valid` stays 1 and no overrun occurs.
- Simultaneous stop-bit sampling and start bit: not possible. A new start bit is recognised only in IDLE, on the first `bit_en` after STOP.
- When `bit_en`=0: no state or register changes, except that the output handshake still operates.

Optional Feature:
- Macro: XOR_PARITY_RX_STATS_EN.
- When defined:
  - Adds two outputs: `par_err_cnt` [15:0] and `frm_err_cnt` [15:0].
  - `par_err_cnt` counts committed words with `parity_err`=1.
  - `frm_err_cnt` counts `frame_err` pulses.
  - Both counters saturate at 0xFFFF and reset to 0.
- When undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package `xor_parity_pkg`:
  - FSM state encoding (`IDLE`=0, `DATA`=1, `PARITY`=2, `STOP`=3).
  - Localparam `CNT_W` = `$clog2(DATA_W)`.
  - Stats counter width = 16.
- Sub-module `xor_parity_acc`:
  - Single-bit running XOR with clear/preset-to-ODD_PARITY and enable.
  - Shared with the transmitter-side generator.

Test Plan:
- Reset: hold `rst_n`=0 for 3 cycles with `sin` toggling -> all outputs 0 and the FSM in IDLE; a frame started mid-reset produces no `dout_valid`.
- Good frame, even mode: send start 0, data 0xA5 LSB first, parity 0, stop 1 -> `dout`=0xA5, `dout_valid`=1 the cycle after the stop strobe, `parity_err`=0.
- Bad parity: data 0x01 with parity bit 0 -> `dout`=0x01, `parity_err`=1; with the STATS macro defined, `par_err_cnt`=1.
- Framing error: data 0x3C with stop bit 0 -> one-cycle `frame_err` pulse, `dout_valid` stays 0, and the next good frame 0x3C is received normally.
- Overrun: `dout_ready`=0; send 0x11 then 0x22 -> `dout` stays 0x11 and `overrun`=1. Raise `dout_ready` -> 0x11 accepted, `dout_valid`=0, `overrun` remains 1.
- Back-to-back with ready and gapped strobes: `bit_en` every 4th cycle, `dout_ready`=1, frames 0x00, 0xFF, 0x5A sent consecutively -> three words in order, each with `parity_err`=0 and no overrun. Repeat with ODD_PARITY=1 and inverted parity bits.
